// File: rtl/apb_pkg.sv
// Shared types for the APB master arbiter: sequencer state encoding and default widths.
// The state encoding matches the APB slave so traces read the same on both sides.
package apb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin pick. When both requesters are asking, the one that did not
// win last time gets the grant. The pointer register lives in the master.
module apb_rr_arbiter (
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    output logic [1:0] o_gnt
);
    assign o_gnt[0] = i_req[0] & (~i_req[1] |  i_last_gnt);
    assign o_gnt[1] = i_req[1] & (~i_req[0] | ~i_last_gnt);
endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two local requesters: round-robin arbitration, SETUP/ACCESS
// sequencing with a bounded wait on P_ready, and per-requester result registers.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              P_clk,
    input  logic              P_rst_n,
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] P_addr,
    output logic              P_selx,
    output logic              P_enable,
    output logic              P_write,
    output logic [DATA_W-1:0] P_wdata,
    input  logic              P_ready,
    input  logic              P_slverr,
    input  logic [DATA_W-1:0] P_rdata
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_e        r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_last_gnt, w_last_gnt;
    logic [1:0]        w_arb, w_gnt, w_done;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata, w_rdata0, w_rdata1, w_fin_rdata;
    logic              w_write, w_selx, w_enable, w_err0, w_err1;
    logic              w_fin, w_fin_err, w_cnt_last;

    apb_rr_arbiter u_arb (
        .i_req      ({r1_req, r0_req}),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_arb)
    );

    // With TIMEOUT == 0 the compare is masked off and the counter just wraps.
    assign w_cnt_last = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_last_gnt  = r_last_gnt;
        w_addr      = P_addr;
        w_write     = P_write;
        w_wdata     = P_wdata;
        w_selx      = P_selx;
        w_enable    = P_enable;
        w_gnt       = 2'b00;
        w_done      = 2'b00;
        w_rdata0    = r0_rdata;
        w_rdata1    = r1_rdata;
        w_err0      = r0_err;
        w_err1      = r1_err;
        w_fin       = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_rdata = '0;
        case (r_state)
            IDLE: begin
                w_selx   = 1'b0;
                w_enable = 1'b0;
                if (|w_arb) begin
                    w_state    = SETUP;
                    w_selx     = 1'b1;
                    w_gnt      = w_arb;
                    w_last_gnt = w_arb[1];
                    w_addr     = w_arb[1] ? r1_addr  : r0_addr;
                    w_write    = w_arb[1] ? r1_write : r0_write;
                    w_wdata    = w_arb[1] ? r1_wdata : r0_wdata;
                end
            end
            SETUP: begin
                w_state  = ACCESS;
                w_enable = 1'b1;
                w_cnt    = '0;
            end
            ACCESS: begin
                if (P_ready) begin
                    w_fin       = 1'b1;
                    w_fin_err   = P_slverr;
                    w_fin_rdata = P_write ? '0 : P_rdata;
                end else if (w_cnt_last) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state = IDLE;
        endcase
        // r_last_gnt still names the owner of the transfer in flight.
        if (w_fin) begin
            w_state              = IDLE;
            w_selx               = 1'b0;
            w_enable             = 1'b0;
            w_done[r_last_gnt]   = 1'b1;
            if (r_last_gnt) begin
                w_rdata1 = w_fin_rdata;
                w_err1   = w_fin_err;
            end else begin
                w_rdata0 = w_fin_rdata;
                w_err0   = w_fin_err;
            end
        end
    end

    always_ff @(posedge P_clk or negedge P_rst_n) begin
        if (!P_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last_gnt <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_last_gnt <= w_last_gnt;
        end
    end

    always_ff @(posedge P_clk or negedge P_rst_n) begin
        if (!P_rst_n) begin
            P_addr   <= '0;
            P_write  <= 1'b0;
            P_wdata  <= '0;
            P_selx   <= 1'b0;
            P_enable <= 1'b0;
            r0_gnt   <= 1'b0;
            r1_gnt   <= 1'b0;
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            r0_rdata <= '0;
            r1_rdata <= '0;
            r0_err   <= 1'b0;
            r1_err   <= 1'b0;
        end else begin
            P_addr   <= w_addr;
            P_write  <= w_write;
            P_wdata  <= w_wdata;
            P_selx   <= w_selx;
            P_enable <= w_enable;
            r0_gnt   <= w_gnt[0];
            r1_gnt   <= w_gnt[1];
            r0_done  <= w_done[0];
            r1_done  <= w_done[1];
            r0_rdata <= w_rdata0;
            r1_rdata <= w_rdata1;
            r0_err   <= w_err0;
            r1_err   <= w_err1;
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench for apb_master_arbiter: the bench plays both requesters and the APB
// slave, and predicts grant order, ACCESS length and results from a transaction model.
module tb_apb_master_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          P_clk = 1'b0;
    logic          P_rst_n;
    logic          r0_req, r0_write, r0_gnt, r0_done, r0_err;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_req, r1_write, r1_gnt, r1_done, r1_err;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic [AW-1:0] P_addr;
    logic          P_selx, P_enable, P_write, P_ready, P_slverr;
    logic [DW-1:0] P_wdata, P_rdata;

    always #5 P_clk = ~P_clk;

    apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .P_clk(P_clk), .P_rst_n(P_rst_n),
        .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .P_addr(P_addr), .P_selx(P_selx), .P_enable(P_enable), .P_write(P_write),
        .P_wdata(P_wdata), .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Transaction-level model state
    logic        m_last;
    logic [31:0] mem [8];
    logic [31:0] m_rdata [2];
    logic        m_err [2];
    logic        c_wr [2];
    logic [31:0] c_addr [2];
    logic [31:0] c_data [2];
    int          c_wt [2];
    logic        c_se [2];
    logic [1:0]  pend;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input int wt, input logic se);
        c_wr[i] = wr; c_addr[i] = a; c_data[i] = d; c_wt[i] = wt; c_se[i] = se;
    endtask

    task automatic drive_cmds();
        r0_write = c_wr[0]; r0_addr = c_addr[0]; r0_wdata = c_data[0];
        r1_write = c_wr[1]; r1_addr = c_addr[1]; r1_wdata = c_data[1];
    endtask

    // Serve one transfer: expect the grant, play the slave, check the result.
    task automatic serve();
        int win, lat, k;
        bit to;
        logic [31:0] exp_rd;
        win = (pend == 2'b11) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge P_clk);
            lat++;
            if (r0_gnt | r1_gnt) break;
        end
        chk("gnt_lat", lat, 1);
        chk("gnt_who", {r1_gnt, r0_gnt}, (win == 1) ? 2'b10 : 2'b01);
        chk("setup_ctl", {P_selx, P_enable, P_write}, {2'b10, c_wr[win]});
        chk("setup_addr", P_addr, c_addr[win]);
        if (c_wr[win]) chk("setup_wdata", P_wdata, c_data[win]);
        m_last = (win == 1);
        pend[win] = 1'b0;
        if (win == 1) r1_req = 1'b0; else r0_req = 1'b0;
        P_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge P_clk);
            if (r0_done | r1_done) break;
            chk("acc_ctl", {P_selx, P_enable, P_write}, {2'b11, c_wr[win]});
            chk("acc_addr", P_addr, c_addr[win]);
            P_ready  = (k == c_wt[win]);
            P_slverr = c_se[win];
            P_rdata  = c_wr[win] ? $urandom : mem[c_addr[win][2:0]];
            k++;
        end
        P_ready = 1'b0;
        P_slverr = 1'b0;
        to = (c_wt[win] >= TO);
        chk("acc_cycles", k, to ? TO : c_wt[win] + 1);
        exp_rd = (to || c_wr[win]) ? 32'h0 : mem[c_addr[win][2:0]];
        if (!to && c_wr[win] && !c_se[win]) mem[c_addr[win][2:0]] = c_data[win];
        m_rdata[win] = exp_rd;
        m_err[win]   = to | c_se[win];
        chk("done_who", {r1_done, r0_done}, (win == 1) ? 2'b10 : 2'b01);
        chk("rdata0", r0_rdata, m_rdata[0]);
        chk("rdata1", r1_rdata, m_rdata[1]);
        chk("err", {r1_err, r0_err}, {m_err[1], m_err[0]});
        chk("idle_bus", {P_selx, P_enable}, 2'b00);
    endtask

    task automatic do_round(input logic [1:0] mask);
        drive_cmds();
        r0_req = mask[0];
        r1_req = mask[1];
        pend = mask;
        while (pend != 2'b00) serve();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        P_rst_n = 1'b0;
        r0_req = 0; r1_req = 0; P_ready = 0; P_slverr = 0; P_rdata = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        for (int i = 0; i < 2; i++) begin
            set_cmd(i, 1'b0, 0, 0, 0, 1'b0);
            m_rdata[i] = '0;
            m_err[i] = 1'b0;
        end
        drive_cmds();
        m_last = 1'b1;
        #12;
        chk("rst_apb", {P_selx, P_enable, P_write, P_addr, P_wdata}, '0);
        chk("rst_req_out", {r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err}, '0);
        chk("rst_rdata", {r0_rdata, r1_rdata}, '0);
        @(negedge P_clk);
        P_rst_n = 1'b1;

        // Zero-wait write, then read-back from the other requester
        set_cmd(0, 1'b1, 32'd5, 32'hA5, 0, 1'b0);
        do_round(2'b01);
        set_cmd(1, 1'b0, 32'd5, 32'h0, 0, 1'b0);
        do_round(2'b10);
        // Simultaneous requests alternate
        for (int r = 0; r < 2; r++) begin
            set_cmd(0, 1'b1, 32'd1 + r, 32'h100 + r, 0, 1'b0);
            set_cmd(1, 1'b0, 32'd5, 32'h0, 0, 1'b0);
            do_round(2'b11);
        end
        // Timeout on a read, then wait states with slave error
        set_cmd(0, 1'b0, 32'd5, 32'h0, 20, 1'b0);
        do_round(2'b01);
        set_cmd(1, 1'b1, 32'd3, 32'hDEAD, 3, 1'b1);
        do_round(2'b10);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 2; i++)
                set_cmd(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom,
                        ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 4))
                                                     : int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 5) == 0));
            do_round(2'($urandom_range(1, 3)));
        end

        // Reset in the middle of ACCESS aborts without a done pulse
        set_cmd(1, 1'b1, 32'd7, 32'h77, 0, 1'b0);
        drive_cmds();
        r1_req = 1'b1;
        @(negedge P_clk);
        chk("abort_gnt", {r1_gnt, r0_gnt}, 2'b10);
        r1_req = 1'b0;
        @(negedge P_clk);
        chk("abort_acc", {P_selx, P_enable}, 2'b11);
        #2 P_rst_n = 1'b0;
        #1;
        chk("abort_bus", {P_selx, P_enable}, 2'b00);
        chk("abort_done", {r1_done, r0_done}, 2'b00);
        @(negedge P_clk);
        P_rst_n = 1'b1;
        m_last = 1'b1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_err[0] = 1'b0; m_err[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge P_clk);
            chk("post_abort_quiet", {r1_done, r0_done, P_selx}, 3'b000);
        end
        set_cmd(0, 1'b0, 32'd1, 32'h0, 1, 1'b0);
        set_cmd(1, 1'b0, 32'd2, 32'h0, 0, 1'b0);
        do_round(2'b11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
